// File: rtl/filter_test_pkg.sv
// Shared definitions for the filter test capture path: readout FSM states and
// default RAM geometry used by both the capture and readout sides.
package filter_test_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } readout_state_t;

endpackage

// File: rtl/readout_skid_fifo.sv
// Two-entry FIFO between the RAM read port and the output stream. When empty,
// a word arriving this cycle is presented straight through so the first word
// leaves the cycle it returns from the RAM.
module readout_skid_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == 2'd0);
    assign valid = !empty || push;
    assign dout  = !empty ? mem[rd_ptr] : (push ? din : '0);

    // A word pushed and popped in the same cycle while empty bypasses storage.
    assign wr_en = push && !(pop && empty);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(wr_en) - 2'(rd_en);
        end
    end

endmodule

// File: rtl/capture_readout.sv
// Walks the capture result RAM from address 0 to LAST_ADDR and streams each
// word on a valid/ready port, one word per cycle when the consumer keeps up.
module capture_readout
    import filter_test_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LAST_ADDR = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    readout_state_t state;
    logic           inflight;
    logic           inflight_last;
    logic           at_last;
    logic           pop;
    logic [1:0]     fifo_count;
    logic [2:0]     occupancy;
    logic [DATA_W:0] fifo_dout;

    assign at_last   = (ram_addr == ADDR_W'(LAST_ADDR));
    assign pop       = out_valid && out_ready;

    // Only issue a read if its word is guaranteed a FIFO slot on return.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign ram_rden  = (state == FETCH) && (occupancy < 3'd2);

    assign out_last  = fifo_dout[DATA_W];
    assign out_data  = fifo_dout[DATA_W-1:0];

    readout_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({inflight_last, ram_q}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (out_valid),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_addr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= ram_rden;
            inflight_last <= ram_rden && at_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (ram_rden) begin
                        if (at_last) begin
                            state <= DRAIN;
                        end else begin
                            ram_addr <= ram_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ram_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: RAM model, per-cycle scoreboard of the expected
// word sequence, busy/done timing, backpressure, restart, reset and short dump.
module tb_capture_readout;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int          LAST   = 255;
    localparam logic [31:0] BASE   = 32'hA500_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, out_ready;
    logic              busy, done, ram_rden, out_valid, out_last;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q, out_data;

    logic              start3, ready3;
    logic              busy3, done3, ram_rden3, valid3, last3;
    logic [ADDR_W-1:0] ram_addr3;
    logic [DATA_W-1:0] ram_q3, data3;

    capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_q(ram_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .ram_addr(ram_addr3), .ram_rden(ram_rden3), .ram_q(ram_q3),
        .out_data(data3), .out_valid(valid3), .out_ready(ready3),
        .out_last(last3)
    );

    // Synchronous-read RAM preloaded with mem[a] = BASE + a.
    always @(posedge clk) if (ram_rden)  ram_q  <= BASE + 32'(ram_addr);
    always @(posedge clk) if (ram_rden3) ram_q3 <= BASE + 32'(ram_addr3);

    int n_cmp = 0, n_err = 0, cyc = 0;
    int exp_idx = 0;
    bit active = 0, done_due = 0, prev_stall = 0;
    int hs_count, last_count, dut_dones, first_valid_cyc, last_hs_cyc, done_cyc;
    int ready_mode = 0;
    bit ready_val = 1, start_req = 0, rst_req = 0, start3_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        hs_count = 0; last_count = 0; dut_dones = 0;
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    endtask

    // One clock: drive this cycle's inputs, sample outputs, advance the model.
    task automatic tick();
        bit hs, was_done;
        @(posedge clk); #1;
        rst = rst_req; start = start_req; start3 = start3_req;
        out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : ready_val;
        #1;
        cyc++;
        chk("busy", 32'(busy), 32'(active));
        chk("done", 32'(done), 32'(done_due));
        if (!active) begin
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_rden", 32'(ram_rden), 0);
        end
        if (prev_stall) chk("hold_valid", 32'(out_valid), 1);
        if (out_valid) begin
            chk("word", out_data, BASE + 32'(exp_idx));
            chk("word_last", 32'(out_last), 32'(exp_idx == LAST));
        end
        if (done) begin dut_dones++; done_cyc = cyc; end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        hs = out_valid && out_ready;
        if (rst) begin
            active = 0; done_due = 0; exp_idx = 0; prev_stall = 0;
        end else begin
            was_done = done_due;
            done_due = hs && (exp_idx == LAST);
            if (hs) begin
                hs_count++; last_hs_cyc = cyc; exp_idx++;
                if (out_last) last_count++;
            end
            prev_stall = out_valid && !out_ready;
            if (!active && !was_done && start) begin active = 1; exp_idx = 0; end
            if (done_due) active = 0;
        end
    endtask

    task automatic run_to_done(input string tag, input int budget);
        for (int i = 0; i < budget && dut_dones == 0; i++) tick();
        chk(tag, 32'(dut_dones > 0), 1);
        repeat (3) tick();
    endtask

    task automatic run_until_idx(input string tag, input int idx);
        for (int i = 0; i < 2000 && exp_idx != idx; i++) tick();
        chk(tag, 32'(exp_idx), 32'(idx));
    endtask

    task automatic check_dump(input string tag);
        chk({tag, "_words"}, 32'(hs_count), 256);
        chk({tag, "_lasts"}, 32'(last_count), 1);
        chk({tag, "_dones"}, 32'(dut_dones), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rden"}, 32'(ram_rden), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_addr"}, 32'(ram_addr), 0);
        chk({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        int s, k;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; start3 = 1'b0; ready3 = 1'b1;
        ram_q = '0; ram_q3 = '0;

        rst_req = 1; tick(); tick(); rst_req = 0; tick();
        check_zero("reset");
        chk("reset3_busy", 32'(busy3), 0);
        chk("reset3_valid", 32'(valid3), 0);
        chk("reset3_addr", 32'(ram_addr3), 0);

        // Full-throughput dump with latency and bubble-free checks.
        clear_stats();
        start_req = 1; tick(); s = cyc; start_req = 0;
        tick();
        chk("first_rden", 32'(ram_rden), 1);
        chk("first_addr", 32'(ram_addr), 0);
        run_to_done("full_timeout", 400);
        check_dump("full");
        chk("full_first_valid", 32'(first_valid_cyc), 32'(s + 2));
        chk("full_last_hs", 32'(last_hs_cyc), 32'(s + 257));
        chk("full_done_cyc", 32'(done_cyc), 32'(s + 258));

        // Stall 10 cycles with word 5 at the head.
        clear_stats();
        start_req = 1; tick(); start_req = 0;
        run_until_idx("bp_reach", 5);
        ready_val = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", out_data, BASE + 32'd5);
            if (i >= 1) begin
                chk("bp_rden", 32'(ram_rden), 0);
                chk("bp_addr", 32'(ram_addr), 7);
            end
        end
        ready_val = 1;
        run_to_done("bp_timeout", 400);
        check_dump("bp");

        // Random 50% backpressure over a full dump.
        clear_stats();
        ready_mode = 1;
        start_req = 1; tick(); start_req = 0;
        run_to_done("rand_timeout", 3000);
        check_dump("rand");
        ready_mode = 0;

        // Start while busy is ignored.
        clear_stats();
        start_req = 1; tick(); start_req = 0;
        run_until_idx("restart_reach", 100);
        start_req = 1; tick(); start_req = 0;
        run_to_done("restart_timeout", 400);
        check_dump("restart");

        // Reset mid-dump aborts; a fresh start dumps everything again.
        clear_stats();
        start_req = 1; tick(); start_req = 0;
        run_until_idx("rst_reach", 50);
        rst_req = 1; tick(); rst_req = 0;
        tick();
        check_zero("rst_mid");
        repeat (3) tick();
        chk("rst_no_done", 32'(dut_dones), 0);
        clear_stats();
        start_req = 1; tick(); start_req = 0;
        run_to_done("fresh_timeout", 400);
        check_dump("fresh");

        // Short dump on the LAST_ADDR=3 instance.
        start3_req = 1; tick(); s = cyc; start3_req = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            k = c - 2;
            chk("d3_rden", 32'(ram_rden3), 32'(c <= 4));
            if (c <= 4) chk("d3_addr", 32'(ram_addr3), 32'(c - 1));
            chk("d3_addr_max", 32'(ram_addr3 <= 8'd3), 1);
            chk("d3_valid", 32'(valid3), 32'(k >= 0 && k <= 3));
            if (k >= 0 && k <= 3) begin
                chk("d3_data", data3, BASE + 32'(k));
                chk("d3_last", 32'(last3), 32'(k == 3));
            end
            chk("d3_done", 32'(done3), 32'(c == 6));
            chk("d3_busy", 32'(busy3), 32'(c <= 5));
        end
        chk("d3_cycles", 32'(cyc - s), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
